// File: rtl/super_pkg.sv
// Shared LSU request types: request payload, its null value and the arbiter source ids.
package super_pkg;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        we;
        logic [1:0]  size;
        logic        early_load;
        logic        cheri_en;
        logic [3:0]  cheri_perms;
    } lsu_req_info_t;

    localparam lsu_req_info_t NULL_LSU_REQ_INFO = '{
        addr:        32'h0000_0000,
        wdata:       32'h0000_0000,
        we:          1'b0,
        size:        2'b00,
        early_load:  1'b0,
        cheri_en:    1'b0,
        cheri_perms: 4'h0
    };

    typedef enum logic {
        SRC_ISSUE = 1'b0,
        SRC_DRAIN = 1'b1
    } lsu_arb_src_e;

endpackage

// File: rtl/lsu_arb_starve_cnt.sv
// Saturating starvation counter for the drain requester; clear has priority over increment.
module lsu_arb_starve_cnt #(
    parameter int StarveLimit = 4,
    parameter int CntW        = $clog2(StarveLimit + 1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clr,
    input  logic            inc,
    output logic [CntW-1:0] cnt,
    output logic            at_limit
);

    localparam logic [CntW-1:0] Limit = CntW'(StarveLimit);

    // Count lost-arbitration cycles, holding once the limit is reached.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= {CntW{1'b0}};
        end else if (clr) begin
            cnt <= {CntW{1'b0}};
        end else if (inc && (cnt != Limit)) begin
            cnt <= cnt + CntW'(1);
        end else begin
            cnt <= cnt;
        end
    end

    assign at_limit = (cnt == Limit);

endmodule

// File: rtl/lsu_req_arb.sv
// Two-requester arbiter (speculative issue vs. committed drain) feeding one registered
// output slot towards the LSU interface stage.
module lsu_req_arb
    import super_pkg::*;
#(
    parameter int StarveLimit = 4,
    parameter int CntW        = $clog2(StarveLimit + 1)
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                flush_i,
    input  logic [1:0]          req_valid_i,
    input  lsu_req_info_t [1:0] req_info_i,
    output logic [1:0]          req_ready_o,
    output logic                us_valid_o,
    output lsu_req_info_t       us_req_o,
    output logic                us_src_o,
    input  logic                lsif_rdy_i
);

    logic            slot_free;
    logic            pri1;
    logic            elig0;
    logic            gnt0;
    logic            gnt1;
    logic            cnt_clr;
    logic            cnt_inc;
    logic [CntW-1:0] starve_cnt;

    // Grant logic: each ready depends only on the competing requester's claim.
    always_comb begin
        slot_free      = ~us_valid_o | lsif_rdy_i;
        elig0          = ~flush_i;
        req_ready_o[0] = slot_free & elig0 & ~(pri1 & req_valid_i[1]);
        req_ready_o[1] = slot_free & (pri1 | ~(elig0 & req_valid_i[0]));
        gnt0           = req_valid_i[0] & req_ready_o[0];
        gnt1           = req_valid_i[1] & req_ready_o[1];
        cnt_clr        = ~req_valid_i[1] | gnt1;
        // Backpressure stalls (slot not free) are not counted as starvation.
        cnt_inc        = req_valid_i[1] & ~req_ready_o[1] & slot_free;
    end

    // Output slot: load on grant, drop issue entries on flush, clear on pop.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            us_valid_o <= 1'b0;
            us_src_o   <= SRC_ISSUE;
            us_req_o   <= NULL_LSU_REQ_INFO;
        end else if (gnt0 || gnt1) begin
            us_valid_o <= 1'b1;
            us_src_o   <= gnt1 ? SRC_DRAIN : SRC_ISSUE;
            us_req_o   <= gnt1 ? req_info_i[1] : req_info_i[0];
        end else if (flush_i && us_valid_o && (us_src_o == SRC_ISSUE)) begin
            us_valid_o <= 1'b0;
            us_src_o   <= us_src_o;
            us_req_o   <= us_req_o;
        end else if (us_valid_o && lsif_rdy_i) begin
            us_valid_o <= 1'b0;
            us_src_o   <= us_src_o;
            us_req_o   <= us_req_o;
        end else begin
            us_valid_o <= us_valid_o;
            us_src_o   <= us_src_o;
            us_req_o   <= us_req_o;
        end
    end

    lsu_arb_starve_cnt #(
        .StarveLimit (StarveLimit),
        .CntW        (CntW)
    ) u_starve_cnt (
        .clk      (clk_i),
        .rst      (rst_i),
        .clr      (cnt_clr),
        .inc      (cnt_inc),
        .cnt      (starve_cnt),
        .at_limit (pri1)
    );

endmodule

// File: tb/tb_lsu_req_arb.sv
// Self-checking bench for lsu_req_arb: vector table, directed corner sequences and
// randomized traffic against a priority-list reference model.
module tb_lsu_req_arb;
    import super_pkg::*;

    localparam int LIMIT = 4;

    logic                clk;
    logic                rst;
    logic                flush;
    logic [1:0]          req_valid;
    lsu_req_info_t [1:0] req_info;
    logic [1:0]          req_ready;
    logic                us_valid;
    lsu_req_info_t       us_req;
    logic                us_src;
    logic                lsif_rdy;

    lsu_req_arb #(.StarveLimit(LIMIT)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .flush_i     (flush),
        .req_valid_i (req_valid),
        .req_info_i  (req_info),
        .req_ready_o (req_ready),
        .us_valid_o  (us_valid),
        .us_req_o    (us_req),
        .us_src_o    (us_src),
        .lsif_rdy_i  (lsif_rdy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state: one slot plus a starvation count.
    logic          m_valid;
    logic          m_src;
    lsu_req_info_t m_req;
    int            m_cnt;
    logic [1:0]    last_ready;

    typedef struct {
        logic [1:0] v;
        logic       fl;
        logic       rdy;
        logic [1:0] e_rdy;
        logic       e_val;
        logic       e_src;
        int         e_cnt;
    } vec_t;

    vec_t tbl[14];

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void chk_req(string name, lsu_req_info_t act, lsu_req_info_t exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic lsu_req_info_t rand_info();
        lsu_req_info_t r;
        r.addr        = $urandom();
        r.wdata       = $urandom();
        r.we          = 1'($urandom_range(1, 0));
        r.size        = 2'($urandom_range(3, 0));
        r.early_load  = 1'($urandom_range(1, 0));
        r.cheri_en    = 1'($urandom_range(1, 0));
        r.cheri_perms = 4'($urandom_range(15, 0));
        return r;
    endfunction

    // Walk requesters in priority order; the first eligible valid one blocks the rest.
    function automatic logic [1:0] exp_ready(logic [1:0] v, logic fl, logic rdy);
        logic [1:0] res;
        int         order[2];
        bit         blocked;
        bit         free;
        bit         elig;
        int         r;
        res     = 2'b00;
        blocked = 0;
        free    = !m_valid || rdy;
        if (m_cnt == LIMIT) begin
            order[0] = 1; order[1] = 0;
        end else begin
            order[0] = 0; order[1] = 1;
        end
        for (int k = 0; k < 2; k++) begin
            r    = order[k];
            elig = (r == 1) || !fl;
            if (free && elig && !blocked) res[r] = 1'b1;
            if (elig && v[r]) blocked = 1;
        end
        return res;
    endfunction

    task automatic model_reset();
        m_valid = 1'b0;
        m_src   = 1'b0;
        m_req   = NULL_LSU_REQ_INFO;
        m_cnt   = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1; req_valid = 2'b00; flush = 1'b0; lsif_rdy = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic step(input logic [1:0] v, input logic fl, input logic rdy,
                        input lsu_req_info_t i0, input lsu_req_info_t i1);
        logic [1:0] er;
        bit         free;
        bit         g0;
        bit         g1;
        req_valid = v; flush = fl; lsif_rdy = rdy;
        req_info[0] = i0; req_info[1] = i1;
        #1;
        er = exp_ready(v, fl, rdy);
        chk("req_ready", 32'(req_ready), 32'(er));
        last_ready = req_ready;
        free = !m_valid || rdy;
        g0 = v[0] && er[0];
        g1 = v[1] && er[1];
        if (g0 || g1) begin
            m_valid = 1'b1;
            m_src   = g1;
            m_req   = g1 ? i1 : i0;
        end else if (m_valid && fl && !m_src) begin
            m_valid = 1'b0;
        end else if (m_valid && rdy) begin
            m_valid = 1'b0;
        end
        if (!v[1] || g1) m_cnt = 0;
        else if (free && m_cnt < LIMIT) m_cnt++;
        @(posedge clk); #1;
        chk("us_valid", 32'(us_valid), 32'(m_valid));
        chk("us_src", 32'(us_src), 32'(m_src));
        chk("starve_cnt", 32'(dut.starve_cnt), 32'(m_cnt));
        if (m_valid) chk_req("us_req", us_req, m_req);
    endtask

    initial begin
        lsu_req_info_t       held;
        lsu_req_info_t       sent;
        rst = 1'b1; flush = 1'b0; lsif_rdy = 1'b0; req_valid = 2'b00;
        req_info[0] = NULL_LSU_REQ_INFO; req_info[1] = NULL_LSU_REQ_INFO;
        model_reset();
        @(posedge clk); #1;
        chk("rst_valid", 32'(us_valid), 32'd0);
        chk("rst_src", 32'(us_src), 32'd0);
        chk("rst_cnt", 32'(dut.starve_cnt), 32'd0);
        chk_req("rst_req", us_req, NULL_LSU_REQ_INFO);
        rst = 1'b0;

        //          v      fl    rdy   e_rdy  e_val e_src e_cnt
        tbl[0]  = '{2'b01, 1'b0, 1'b1, 2'b01, 1'b1, 1'b0, 0};
        tbl[1]  = '{2'b11, 1'b0, 1'b1, 2'b01, 1'b1, 1'b0, 1};
        tbl[2]  = '{2'b11, 1'b0, 1'b1, 2'b01, 1'b1, 1'b0, 2};
        tbl[3]  = '{2'b11, 1'b0, 1'b1, 2'b01, 1'b1, 1'b0, 3};
        tbl[4]  = '{2'b11, 1'b0, 1'b1, 2'b01, 1'b1, 1'b0, 4};
        tbl[5]  = '{2'b11, 1'b0, 1'b1, 2'b10, 1'b1, 1'b1, 0};
        tbl[6]  = '{2'b11, 1'b0, 1'b0, 2'b00, 1'b1, 1'b1, 0};
        tbl[7]  = '{2'b11, 1'b1, 1'b0, 2'b00, 1'b1, 1'b1, 0};
        tbl[8]  = '{2'b00, 1'b0, 1'b1, 2'b11, 1'b0, 1'b1, 0};
        tbl[9]  = '{2'b01, 1'b0, 1'b0, 2'b01, 1'b1, 1'b0, 0};
        tbl[10] = '{2'b01, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 0};
        tbl[11] = '{2'b10, 1'b1, 1'b0, 2'b10, 1'b1, 1'b1, 0};
        tbl[12] = '{2'b11, 1'b1, 1'b1, 2'b10, 1'b1, 1'b1, 0};
        tbl[13] = '{2'b00, 1'b0, 1'b1, 2'b11, 1'b0, 1'b1, 0};
        for (int i = 0; i < 14; i++) begin
            step(tbl[i].v, tbl[i].fl, tbl[i].rdy, rand_info(), rand_info());
            chk("tbl_ready", 32'(last_ready), 32'(tbl[i].e_rdy));
            chk("tbl_valid", 32'(us_valid), 32'(tbl[i].e_val));
            chk("tbl_src", 32'(us_src), 32'(tbl[i].e_src));
            chk("tbl_cnt", 32'(dut.starve_cnt), 32'(tbl[i].e_cnt));
        end

        // Requester 0 stream: each payload appears one cycle after its grant, in order.
        do_reset();
        for (int k = 0; k < 5; k++) begin
            sent = rand_info();
            step(2'b01, 1'b0, 1'b1, sent, rand_info());
            chk("stream_valid", 32'(us_valid), 32'd1);
            chk("stream_src", 32'(us_src), 32'd0);
            chk_req("stream_req", us_req, sent);
        end
        step(2'b00, 1'b0, 1'b1, rand_info(), rand_info());
        chk("stream_drain", 32'(us_valid), 32'd0);

        // Both requesters valid: grants 0,0,0,0,1 with counts 0..4 ahead of each drain grant.
        do_reset();
        for (int k = 0; k < 10; k++) begin
            chk("pat_cnt", 32'(dut.starve_cnt), 32'(k % 5));
            step(2'b11, 1'b0, 1'b1, rand_info(), rand_info());
            chk("pat_src", 32'(us_src), ((k % 5) == 4) ? 32'd1 : 32'd0);
        end

        // Downstream backpressure: slot content stable, no starvation counted, no readies.
        held = rand_info();
        step(2'b01, 1'b0, 1'b1, held, rand_info());
        for (int k = 0; k < 10; k++) begin
            step(2'b11, 1'b0, 1'b0, rand_info(), rand_info());
            chk("bp_ready", 32'(last_ready), 32'd0);
            chk_req("bp_req", us_req, held);
            chk("bp_cnt", 32'(dut.starve_cnt), 32'd0);
        end

        // Reset with slot full and count at 3.
        for (int k = 0; k < 3; k++) step(2'b11, 1'b0, 1'b1, rand_info(), rand_info());
        chk("pre_rst_cnt", 32'(dut.starve_cnt), 32'd3);
        rst = 1'b1; req_valid = 2'b11; lsif_rdy = 1'b0; flush = 1'b0;
        #1;
        chk("rst_full_ready", 32'(req_ready), 32'd0);
        @(posedge clk); #1;
        chk("mid_rst_valid", 32'(us_valid), 32'd0);
        chk("mid_rst_cnt", 32'(dut.starve_cnt), 32'd0);
        rst = 1'b0;
        model_reset();

        // Randomized traffic against the reference model.
        for (int k = 0; k < 400; k++) begin
            step(2'($urandom_range(3, 0)), ($urandom_range(7, 0) == 0),
                 ($urandom_range(9, 0) < 7), rand_info(), rand_info());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
